// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order fetches on a req/gnt bus,
// buffers responses in a 2-entry queue for decode and applies stall/flush redirects.
module ifu_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ac2if_stall,
    input  logic              ac2if_flush,
    input  logic [ADDR_W-1:0] ac2if_flush_pc,
    output logic              if2ac_hazard,
    output logic              if2mem_req,
    output logic [ADDR_W-1:0] if2mem_addr,
    input  logic              mem2if_gnt,
    input  logic              mem2if_rvalid,
    input  logic [DATA_W-1:0] mem2if_rdata,
    input  logic              mem2if_err,
    output logic              if2id_valid,
    output logic [ADDR_W-1:0] if2id_pc,
    output logic [DATA_W-1:0] if2id_instr,
    output logic              if2id_fault
);

    typedef enum logic {S_FETCH, S_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              fault;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        ost_q, ost_d;
    logic [1:0]        discard_q, discard_d;
    logic [1:0]        q_cnt_q;
    logic              rd_ptr_q, wr_ptr_q;
    entry_t            q_mem [2];
    entry_t            head;

    logic              fire, push, pop;
    logic [2:0]        credit_used;
    logic [ADDR_W-1:0] resp_pc;

    assign credit_used = {1'b0, ost_q} + {1'b0, q_cnt_q};

    // req is held low while in reset so every output sits at its reset value
    assign if2mem_req  = rstn & (state_q == S_FETCH) & ~ac2if_flush & (credit_used < 3'd2);
    assign if2mem_addr = pc_q;

    assign fire = if2mem_req & mem2if_gnt;
    assign push = mem2if_rvalid & (state_q == S_FETCH) & ~ac2if_flush;
    assign pop  = if2id_valid & ~ac2if_stall & ~ac2if_flush;

    // Responses return in issue order: the oldest outstanding fetch is ost_q words behind pc_q
    assign resp_pc = pc_q - ADDR_W'({ost_q, 2'b00});

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        ost_d     = ost_q;
        discard_d = discard_q;
        if (ac2if_flush) begin
            pc_d      = {ac2if_flush_pc[ADDR_W-1:2], 2'b00};
            ost_d     = 2'd0;
            // ost_q and discard_q are never both non-zero, so the sum still fits
            discard_d = ost_q + discard_q - {1'b0, mem2if_rvalid};
            state_d   = (discard_d != 2'd0) ? S_DRAIN : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fire) pc_d = pc_q + ADDR_W'(4);
                    ost_d = ost_q + {1'b0, fire} - {1'b0, mem2if_rvalid};
                end
                S_DRAIN: begin
                    if (mem2if_rvalid) discard_d = discard_q - 2'd1;
                    if (discard_d == 2'd0) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ost_q     <= 2'd0;
            discard_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ost_q     <= ost_d;
            discard_q <= discard_d;
        end
    end

    // NOTE: the queue storage is reset as well, so the decode outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_cnt_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            q_mem[0] <= '0;
            q_mem[1] <= '0;
        end else if (ac2if_flush) begin
            q_cnt_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                q_mem[wr_ptr_q] <= {resp_pc, mem2if_rdata, mem2if_err};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            q_cnt_q <= q_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head         = q_mem[rd_ptr_q];
    assign if2id_valid  = (q_cnt_q != 2'd0);
    assign if2id_pc     = head.pc;
    assign if2id_instr  = head.instr;
    assign if2id_fault  = head.fault;
    assign if2ac_hazard = (state_q == S_DRAIN);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a list-based model of outstanding fetches and the decode queue.
module tb_ifu_fetch;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ac2if_stall = 1'b0, ac2if_flush = 1'b0;
    logic [AW-1:0] ac2if_flush_pc = '0;
    logic          if2ac_hazard, if2mem_req;
    logic [AW-1:0] if2mem_addr;
    logic          mem2if_gnt = 1'b0, mem2if_rvalid = 1'b0, mem2if_err = 1'b0;
    logic [DW-1:0] mem2if_rdata = '0;
    logic          if2id_valid, if2id_fault;
    logic [AW-1:0] if2id_pc;
    logic [DW-1:0] if2id_instr;

    always #5 clk = ~clk;

    ifu_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn),
        .ac2if_stall(ac2if_stall), .ac2if_flush(ac2if_flush), .ac2if_flush_pc(ac2if_flush_pc),
        .if2ac_hazard(if2ac_hazard),
        .if2mem_req(if2mem_req), .if2mem_addr(if2mem_addr),
        .mem2if_gnt(mem2if_gnt), .mem2if_rvalid(mem2if_rvalid),
        .mem2if_rdata(mem2if_rdata), .mem2if_err(mem2if_err),
        .if2id_valid(if2id_valid), .if2id_pc(if2id_pc),
        .if2id_instr(if2id_instr), .if2id_fault(if2id_fault)
    );

    // Model: every granted fetch is a bus transaction; a flush marks the ones in flight stale
    typedef struct { logic [AW-1:0] addr; bit stale; } txn_t;
    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] instr; bit fault; } ent_t;
    txn_t          oq[$];
    ent_t          dq[$];
    logic [AW-1:0] m_pc;
    bit            m_req;

    logic [AW-1:0] seen_pc[$];
    bit            seen_fault[$];
    bit            g_fire;
    logic [AW-1:0] g_addr;

    // Stimulus knobs
    bit            s_stall, s_flush, s_gnt, want_rv, rand_data, err_en, r_err;
    logic [AW-1:0] s_fpc, err_addr;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic compare();
        bit any_stale = 0;
        int live = 0;
        foreach (oq[i]) begin
            if (oq[i].stale) any_stale = 1;
            else live++;
        end
        m_req = !any_stale && !ac2if_flush && (live + dq.size() < 2);
        check("req", if2mem_req, m_req);
        check("addr", if2mem_addr, m_pc);
        check("hazard", if2ac_hazard, any_stale);
        check("valid", if2id_valid, dq.size() != 0);
        if (dq.size() != 0) begin
            check("id_pc", if2id_pc, dq[0].pc);
            check("id_instr", if2id_instr, dq[0].instr);
            check("id_fault", if2id_fault, dq[0].fault);
        end
        if (if2id_valid === 1'b1 && !ac2if_stall && !ac2if_flush) begin
            seen_pc.push_back(if2id_pc);
            seen_fault.push_back(if2id_fault);
        end
    endtask

    task automatic update();
        txn_t r;
        bit   rpush = 0;
        bit   pop   = dq.size() != 0 && !ac2if_stall && !ac2if_flush;
        if (mem2if_rvalid) begin
            r     = oq.pop_front();
            rpush = !r.stale && !ac2if_flush;
        end
        if (pop) void'(dq.pop_front());
        if (rpush) dq.push_back('{r.addr, mem2if_rdata, mem2if_err});
        g_fire = 0;
        if (ac2if_flush) begin
            dq.delete();
            foreach (oq[i]) oq[i].stale = 1;
            m_pc = {ac2if_flush_pc[AW-1:2], 2'b00};
        end else if (m_req && mem2if_gnt) begin
            oq.push_back('{m_pc, 1'b0});
            g_fire = 1;
            g_addr = m_pc;
            m_pc   = m_pc + 32'd4;
        end
    endtask

    // One clock: drive at the falling edge, compare 1ns later, advance the model
    task automatic cycle();
        logic [AW-1:0] front;
        @(negedge clk);
        front          = (oq.size() != 0) ? oq[0].addr : '0;
        ac2if_stall    = s_stall;
        ac2if_flush    = s_flush;
        ac2if_flush_pc = s_fpc;
        mem2if_gnt     = s_gnt;
        mem2if_rvalid  = want_rv && (oq.size() != 0);
        mem2if_rdata   = rand_data ? $urandom : instr_of(front);
        mem2if_err     = err_en ? (oq.size() != 0 && front == err_addr) : r_err;
        #1;
        compare();
        update();
    endtask

    task automatic set_in(input bit stall, input bit flush, input logic [AW-1:0] fpc,
                          input bit gnt, input bit rv);
        s_stall = stall; s_flush = flush; s_fpc = fpc; s_gnt = gnt; want_rv = rv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        ac2if_stall = 0; ac2if_flush = 0; ac2if_flush_pc = '0;
        mem2if_gnt = 0; mem2if_rvalid = 0; mem2if_rdata = '0; mem2if_err = 0;
        #1;
        check("rst_req", if2mem_req, 0);
        check("rst_addr", if2mem_addr, 32'h0);
        check("rst_valid", if2id_valid, 0);
        check("rst_pc", if2id_pc, 32'h0);
        check("rst_instr", if2id_instr, 32'h0);
        check("rst_fault", if2id_fault, 0);
        check("rst_hazard", if2ac_hazard, 0);
        oq.delete();
        dq.delete();
        m_pc = 32'h0;
        @(negedge clk);
        rstn = 1'b1;
        seen_pc.delete();
        seen_fault.delete();
    endtask

    initial begin
        rand_data = 0; err_en = 0; r_err = 0; err_addr = '0;
        set_in(0, 0, '0, 0, 0);
        do_reset();

        // Streaming with gnt always high and one-cycle response latency
        set_in(0, 0, '0, 1, 1);
        cycle();
        check("t1_g0", {g_fire, g_addr}, {1'b1, 32'h0});
        cycle();
        check("t1_g1", {g_fire, g_addr}, {1'b1, 32'h4});
        check("t1_v_c1", if2id_valid, 0);
        cycle();
        check("t1_v_c2", if2id_valid, 1);
        check("t1_pc_c2", if2id_pc, 32'h0);
        for (int i = 0; i < 8; i++) cycle();
        check("t1_npop", seen_pc.size() >= 3, 1);
        check("t1_pop0", seen_pc[0], 32'h0);
        check("t1_pop1", seen_pc[1], 32'h4);
        check("t1_pop2", seen_pc[2], 32'h8);

        // Stall: two fetches fill the credit, head held, then drained in order
        do_reset();
        begin
            int grants = 0;
            set_in(1, 0, '0, 1, 1);
            for (int i = 0; i < 5; i++) begin
                cycle();
                grants += int'(g_fire);
            end
            check("t2_grants", grants, 2);
            check("t2_req", if2mem_req, 0);
            check("t2_pc", if2id_pc, 32'h0);
            check("t2_instr", if2id_instr, instr_of(32'h0));
        end
        set_in(0, 0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("t2_npop", seen_pc.size(), 2);
        check("t2_pop0", seen_pc[0], 32'h0);
        check("t2_pop1", seen_pc[1], 32'h4);

        // Flush with two fetches outstanding: both responses discarded
        do_reset();
        set_in(0, 1, 32'h10, 1, 0); cycle();
        set_in(0, 0, '0, 1, 0);     cycle();
        check("t3_g10", {g_fire, g_addr}, {1'b1, 32'h10});
        cycle();
        check("t3_g14", {g_fire, g_addr}, {1'b1, 32'h14});
        set_in(0, 1, 32'h200, 1, 0); cycle();
        check("t3_req_flush", if2mem_req, 0);
        set_in(0, 0, '0, 1, 1);
        cycle();
        check("t3_haz0", if2ac_hazard, 1);
        check("t3_req0", if2mem_req, 0);
        cycle();
        check("t3_haz1", if2ac_hazard, 1);
        check("t3_valid", if2id_valid, 0);
        cycle();
        check("t3_haz2", if2ac_hazard, 0);
        check("t3_addr", {g_fire, g_addr}, {1'b1, 32'h200});
        cycle();
        cycle();
        check("t3_v", if2id_valid, 1);
        check("t3_pc", if2id_pc, 32'h200);

        // Unaligned flush target with nothing outstanding; flush beats stall
        do_reset();
        set_in(0, 1, 32'h103, 1, 0); cycle();
        check("t4_req_flush", if2mem_req, 0);
        set_in(0, 0, '0, 1, 1); cycle();
        check("t4_haz", if2ac_hazard, 0);
        check("t4_addr", {if2mem_req, if2mem_addr}, {1'b1, 32'h100});
        set_in(1, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("t4_q", if2id_valid, 1);
        set_in(1, 1, 32'h300, 1, 1); cycle();
        set_in(1, 0, '0, 0, 0); cycle();
        check("t4_v", if2id_valid, 0);
        check("t4_addr2", if2mem_addr, 32'h300);

        // Bus error on the fetch at 0x8 only
        do_reset();
        err_en = 1; err_addr = 32'h8;
        set_in(0, 0, '0, 1, 1);
        for (int i = 0; i < 12; i++) cycle();
        err_en = 0;
        check("t5_npop", seen_pc.size() >= 4, 1);
        check("t5_pc1", {seen_pc[1], 7'd0, seen_fault[1]}, {32'h4, 8'h0});
        check("t5_pc2", {seen_pc[2], 7'd0, seen_fault[2]}, {32'h8, 8'h1});
        check("t5_pc3", {seen_pc[3], 7'd0, seen_fault[3]}, {32'hC, 8'h0});

        // Address wrap, then reset in the middle of a fetch
        do_reset();
        set_in(0, 1, 32'hFFFF_FFFC, 1, 0); cycle();
        set_in(0, 0, '0, 1, 0); cycle();
        check("t6_top", {g_fire, g_addr}, {1'b1, 32'hFFFF_FFFC});
        cycle();
        check("t6_wrap", if2mem_addr, 32'h0);
        do_reset();

        // Random traffic against the model
        rand_data = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            s_gnt   = ($urandom_range(0, 3) != 0);
            s_stall = ($urandom_range(0, 3) == 0);
            s_flush = ($urandom_range(0, 19) == 0);
            s_fpc   = $urandom;
            want_rv = ($urandom_range(0, 2) != 0);
            r_err   = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
